// File: rtl/count_checker_pkg.sv
// Shared types and constants for the count_checker sequence checker.
package count_checker_pkg;

    // Width of the relock counter; RELOCK_N must fit in it (1..15).
    localparam int GOOD_W = 4;

    // Checker lock state.
    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } chk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a same-cycle increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    // Count up on inc, stick at all-ones, clear wins over inc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_checker.sv
// Passive checker for an enabled wrap-around up-counter: predicts the next
// count from the previous sample and enable, flags deviations, tracks lock
// status and keeps saturating error / wrap statistics.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int STAT_WIDTH = 8,
    parameter int RELOCK_N   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [WIDTH-1:0]      count,
    input  logic                  clear,
    output logic                  locked,
    output logic                  err,
    output logic [STAT_WIDTH-1:0] err_count,
    output logic [STAT_WIDTH-1:0] wrap_count
);

    chk_state_t          state_q;
    chk_state_t          state_d;
    logic [WIDTH-1:0]    ref_q;
    logic                en_q;
    logic [GOOD_W-1:0]   good_q;
    logic [GOOD_W-1:0]   good_d;
    logic                err_q;

    logic [WIDTH-1:0]    exp_cnt;
    logic                hit;
    logic                checking;
    logic                err_inc;
    logic                wrap_inc;
    logic [GOOD_W-1:0]   good_inc;
    logic                relock;

    // Prediction and compare; an unknown count falls to the else branch and
    // is therefore treated as a mismatch.
    always_comb begin
        exp_cnt  = en_q ? (ref_q + WIDTH'(1)) : ref_q;
        hit      = 1'b0;
        if (count == exp_cnt) begin
            hit = 1'b1;
        end
        checking = (state_q != ACQUIRE);
        good_inc = good_q + GOOD_W'(1);
        relock   = hit && (good_inc == GOOD_W'(RELOCK_N));
    end

    // State, reference sample, relock counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACQUIRE;
            ref_q   <= '0;
            en_q    <= 1'b0;
            good_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= count;
            en_q    <= en;
            good_q  <= good_d;
            err_q   <= err_inc;
        end
    end

    // Next state and next relock count.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ACQUIRE: begin
                state_d = TRACK;
                good_d  = '0;
            end
            TRACK: begin
                if (!hit) begin
                    state_d = FAULT;
                    good_d  = '0;
                end
            end
            FAULT: begin
                if (!hit) begin
                    good_d = '0;
                end else if (relock) begin
                    state_d = TRACK;
                    good_d  = '0;
                end else begin
                    good_d = good_inc;
                end
            end
            default: begin
                state_d = ACQUIRE;
                good_d  = '0;
            end
        endcase
    end

    // Outputs derived from the registered state and the current compare.
    always_comb begin
        locked   = (state_q == TRACK);
        err      = err_q;
        err_inc  = checking && !hit;
        wrap_inc = checking && hit && en_q &&
                   (ref_q == {WIDTH{1'b1}}) && (count == '0);
    end

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_err_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (err_inc),
        .q     (err_count)
    );

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_wrap_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (wrap_inc),
        .q     (wrap_count)
    );

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker with hand-computed expectations.
module tb_count_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] count;
    logic       clear;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] wrap_count;

    int n_checks;
    int n_fail;

    count_checker #(
        .WIDTH      (4),
        .STAT_WIDTH (8),
        .RELOCK_N   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .count      (count),
        .clear      (clear),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .wrap_count (wrap_count)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point.
    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Present one sample, let the edge take it, settle 1 ns past the edge.
    task automatic step(input logic e, input logic [3:0] c, input logic clr);
        en    = e;
        count = c;
        clear = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_err;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        count    = '0;
        clear    = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        check_eq("rst_locked", int'(locked), 0);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_err_count", int'(err_count), 0);
        check_eq("rst_wrap_count", int'(wrap_count), 0);
        rst_n = 1'b1;

        // Correct counter, 20 cycles, passes 15 -> 0 once.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'(i), 1'b0);
            check_eq("run_err", int'(err), 0);
            check_eq("run_locked", int'(locked), 1);
            if (i == 15) check_eq("pre_wrap", int'(wrap_count), 0);
            if (i == 16) check_eq("post_wrap", int'(wrap_count), 1);
        end
        check_eq("run_err_count", int'(err_count), 0);
        check_eq("run_wrap_count", int'(wrap_count), 1);

        // Count on to 7, then hold with en low for 4 cycles.
        step(1'b1, 4'd4, 1'b0);
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        check_eq("to7_err", int'(err), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'd7, 1'b0);
            check_eq("hold_err", int'(err), 0);
            check_eq("hold_locked", int'(locked), 1);
        end

        // Disabled-hold violation 7 -> 9.
        step(1'b0, 4'd9, 1'b0);
        check_eq("jump_err", int'(err), 1);
        check_eq("jump_err_count", int'(err_count), 1);
        check_eq("jump_locked", int'(locked), 0);

        // Two good edges in FAULT, then another mismatch (expected 11, got 0).
        step(1'b1, 4'd9, 1'b0);
        check_eq("f1_err", int'(err), 0);
        check_eq("f1_locked", int'(locked), 0);
        step(1'b1, 4'd10, 1'b0);
        check_eq("f2_locked", int'(locked), 0);
        step(1'b1, 4'd0, 1'b0);
        check_eq("f_mis_err", int'(err), 1);
        check_eq("f_mis_err_count", int'(err_count), 2);
        check_eq("f_mis_locked", int'(locked), 0);

        // Relock restarts: locked returns on the 4th good edge.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 4'(i), 1'b0);
            check_eq("relock_err", int'(err), 0);
            check_eq("relock_locked", int'(locked), (i == 4) ? 1 : 0);
        end
        check_eq("relock_err_count", int'(err_count), 2);

        // 300 consecutive mismatches: err_count saturates at 255.
        exp_err = 2;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 4'(i % 2), 1'b0);
            if (exp_err < 255) exp_err++;
            check_eq("sat_err", int'(err), 1);
            check_eq("sat_err_count", int'(err_count), exp_err);
        end
        check_eq("sat_locked", int'(locked), 0);

        // Clear together with a mismatch.
        step(1'b0, 4'd0, 1'b1);
        check_eq("clr_err", int'(err), 1);
        check_eq("clr_err_count", int'(err_count), 0);
        check_eq("clr_wrap_count", int'(wrap_count), 0);
        clear = 1'b0;

        // Relock from FAULT and count 0..15,0..11 with one wrap in TRACK.
        for (int k = 0; k < 28; k++) begin
            step(1'b1, 4'(k), 1'b0);
            check_eq("r2_err", int'(err), 0);
            check_eq("r2_locked", int'(locked), (k >= 3) ? 1 : 0);
        end
        check_eq("r2_wrap_count", int'(wrap_count), 1);
        check_eq("r2_err_count", int'(err_count), 0);

        // Asynchronous reset mid-count at 11; counter also resets to 0.
        rst_n = 1'b0;
        count = 4'd0;
        #1;
        check_eq("arst_locked", int'(locked), 0);
        check_eq("arst_err", int'(err), 0);
        check_eq("arst_err_count", int'(err_count), 0);
        check_eq("arst_wrap_count", int'(wrap_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // After release the first edge is an acquire edge: no error.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'(i), 1'b0);
            check_eq("post_rst_err", int'(err), 0);
            check_eq("post_rst_locked", int'(locked), 1);
        end
        check_eq("post_rst_err_count", int'(err_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_checker.md
# count_checker

Passive sequence checker sitting at the consuming end of the enabled wrap-around up-counter's `en`/`count` interface. It samples the counter's enable and output every clock, predicts the next count value, and flags any deviation. It also reports lock status, saturating error and wrap statistics. It is used in simulation benches and as an on-chip self-check beside the counter.

## Interface
- `WIDTH`, 4: width of the observed `count` bus.
- `STAT_WIDTH`, 8: width of the `err_count` and `wrap_count` statistics outputs.
- `RELOCK_N`, 4: consecutive correct predictions required to leave FAULT (range 1..15).

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  counter enable, as driven to the observed counter.
- `count`  in  WIDTH  observed counter output.
- `clear`  in  1  synchronous clear of the statistics.
- `locked`  out  1  high while in TRACK.
- `err`  out  1  one-cycle pulse on each detected mismatch.
- `err_count`  out  STAT_WIDTH  saturating mismatch count.
- `wrap_count`  out  STAT_WIDTH  saturating count of checked all-ones→0 transitions.

## Operation
- Internal registers:
  - `ref`: last sampled `count`.
  - `en_q`: last sampled `en`.
  - `good_cnt`: 4-bit relock counter.
  - state.
- Prediction: `exp = en_q ? ref + 1 : ref`, modulo 2^WIDTH, so all-ones + 1 = 0. `ref` and `en_q` are updated at every edge, in every state.
- States:
  - ACQUIRE: reset state. At the first edge it captures `count`/`en` into `ref`/`en_q` with no check, then goes to TRACK.
  - TRACK: compares `count` to `exp` at every edge.
    - On a match, it stays in TRACK.
    - On a mismatch, it pulses `err`, increments `err_count`, clears `good_cnt` and goes to FAULT.
  - FAULT: resyncs by using the sampled `count` as the new `ref`.
    - On a match, `good_cnt` increments. When it reaches RELOCK_N, the checker goes to TRACK and clears `good_cnt`.
    - On a mismatch, it pulses `err`, increments `err_count` and clears `good_cnt`.
- A wrap is a checked match where `ref` is all-ones, `en_q` is 1 and `count` is 0. Each wrap increments `wrap_count` in both TRACK and FAULT.
- Both statistics saturate at 2^STAT_WIDTH−1 and never roll over.
- `clear` zeroes both statistics and has priority over a same-cycle increment. It does not affect state, `ref`, `good_cnt` or `err`.
- Disabled hold: when `en_q` is 0, the checker expects `count` unchanged. A change is a mismatch.

## Timing
- Sampling: at edge k the checker sees pre-edge `count(k)` and `en(k)`. The counter's update at edge k is checked at edge k+1.
- Latency: `err`, `locked` and the statistics are registered and reflect the comparison made at the same edge, i.e. they are valid in the cycle after the sampled mismatch.
- `err` is high for exactly one cycle per mismatching edge. Back-to-back mismatches give back-to-back high cycles.
- `locked` rises one cycle after the ACQUIRE edge and falls in the same cycle that `err` rises.
- Reset values: `locked`=0, `err`=0, `err_count`=0, `wrap_count`=0, state ACQUIRE, `ref`=0, `en_q`=0, `good_cnt`=0.
- Reset asserted mid-operation clears everything immediately (asynchronous). After release, the first edge is an ACQUIRE edge again, so a counter reset to 0 is never flagged.
- There is no X-check on inputs. An X on `count` compares as a mismatch in simulation.

## Structure
- Package `count_checker_pkg`:
  - state enum typedef `chk_state_t` {ACQUIRE, TRACK, FAULT};
  - localparam for `good_cnt` width (4).
- One sub-module, `sat_counter` (parameter WIDTH; ports `clk`, `rst_n`, `clear`, `inc`, `q`), saturating, with `clear` priority. It is instantiated twice, for `err_count` and `wrap_count`.
- The FSM, prediction and compare logic live in the top module.

## Test plan
- Reset 20 ns, then `en`=1 with a correct counter for 20 cycles → `locked`=1 from cycle 2, `err` never high, `wrap_count`=1 after count passes 15→0.
- `en` dropped for 4 cycles with count held at 7 → no `err`, `locked` stays 1. Count forced 7→9 while `en`=0 → `err` one cycle, `err_count`=1, `locked`=0.
- From FAULT, a correct counter with RELOCK_N=4 → `locked` returns exactly 4 edges after the resync edge. A second mismatch after 2 good edges → `err_count`=2 and the relock count restarts.
- Force 300 mismatches with STAT_WIDTH=8 → `err_count` holds at 255. Pulse `clear` together with a mismatch → `err_count`=0, `err`=1.
- Assert `rst_n` low mid-count at value 11 while the counter also resets to 0 → all outputs 0 immediately. After release, no `err`, and `locked`=1 two cycles later.
